wb_slave_splitter: RTL and testbench
====================================

// Module: wb_slave_splitter
// PURPOSE
//   Single-master, NS-slave pipelined Wishbone address splitter with bus-fault handling; parametrised successor to
//   the SoC-level one-master crossbar. Sits between the CPU Wishbone master and its peripherals (boot ROM, RAMs,
//   GPIO, UART, measure unit). Adds unmapped-address error, response timeout, outstanding limit, fault capture.
// PARAMETERS
//   NS          6              number of slave ports (1..16)
//   SLAVE_ADDR  {NS{32'h0}}    NS*32 base addresses; slave i at bits [32*i +: 32]
//   SLAVE_MASK  {NS{32'h0}}    NS*32 decode masks; same packing
//   MAX_OUT     4              max outstanding accepted requests (1..15)
//   TIMEOUT     1024           cycles without response before fault; 0 disables the timeout
// PORTS
//   wb_clk_i     in   1      bus clock
//   wb_rst_i     in   1      asynchronous reset, active high
//   wbm_cyc_i    in   1      master cycle
//   wbm_stb_i    in   1      master strobe
//   wbm_we_i     in   1      master write enable
//   wbm_adr_i    in   32     master byte address
//   wbm_dat_i    in   32     master write data
//   wbm_sel_i    in   4      master byte select
//   wbm_ack_o    out  1      ack to master
//   wbm_err_o    out  1      error to master (slave err, unmapped, timeout)
//   wbm_stall_o  out  1      stall to master
//   wbm_dat_o    out  32     read data to master
//   wbs_cyc_o    out  NS     per-slave cycle
//   wbs_stb_o    out  NS     per-slave strobe
//   wbs_we_o     out  1      broadcast write enable
//   wbs_adr_o    out  32     broadcast address
//   wbs_dat_o    out  32     broadcast write data
//   wbs_sel_o    out  4      broadcast byte select
//   wbs_ack_i    in   NS     per-slave ack
//   wbs_err_i    in   NS     per-slave error
//   wbs_stall_i  in   NS     per-slave stall
//   wbs_dat_i    in   NS*32  per-slave read data, slave i at [32*i +: 32]
//   fault_o      out  1      1-cycle pulse on unmapped or timeout fault
//   fault_adr_o  out  32     address of the faulting request, held until next fault
// BEHAVIOUR
// - Decode: hit[i] = ((wbm_adr_i ^ SLAVE_ADDR_i) & SLAVE_MASK_i) == 0; lowest hit index wins; no hit = miss.
// - State: IDLE (out_cnt==0), ACTIVE (out_cnt>0, locked to cur), MISS_ERR (one pending unmapped error).
// - out_cnt width $clog2(MAX_OUT+1). +1 on accepted hit; -1 on wbs_ack_i[cur]|wbs_err_i[cur]; both in the
//   same cycle -> unchanged. Responses from slaves other than cur are ignored.
// - wbm_stall_o = cyc&stb & (MISS_ERR | out_cnt==MAX_OUT | (ACTIVE & (miss | idx!=cur)) | wbs_stall_i[target]).
//   A slave switch therefore waits until all responses drain.
// - wbs_cyc_o[i] = wbm_cyc_i & (ACTIVE ? cur==i : stb & idx==i & hit). wbs_stb_o[i] = wbs_cyc_o[i] & wbm_stb_i &
//   no internal stall term (slave's own stall does not gate its stb). Slave cyc is forced 0 in timeout cycle.
// - IDLE, accepted miss -> MISS_ERR; next cycle wbm_err_o=1, fault_o=1, fault_adr_o<=addr; then -> IDLE.
// - Response path is combinational: wbm_ack_o = ACTIVE & wbs_ack_i[cur]; wbm_err_o also ORs wbs_err_i[cur];
//   wbm_dat_o = ACTIVE ? wbs_dat_i[cur] : 0.
// - Timer: cleared on accept, on any cur response, and in IDLE; increments in ACTIVE. At TIMEOUT-1 (TIMEOUT>0):
//   wbm_err_o=1 one cycle, fault_o=1, fault_adr_o<=last accepted address, out_cnt<=0, -> IDLE.
// - wbm_cyc_i low: all wbs_cyc_o/stb_o 0 combinationally; next edge out_cnt, timer, MISS_ERR cleared; no ack/err.
// - Reset (async): out_cnt 0, cur 0, timer 0, IDLE, fault_o 0, fault_adr_o 0; all outputs 0 while held.
// TESTING
// - NS=6, slave2 at 32'h02000000/ffffffc0; read 32'h02000004, ack after 2 cycles -> wbm_ack_o, dat = slave data.
// - 4 pipelined reads to slave0, MAX_OUT=4, slave acks late -> 5th request stalled until first ack.
// - Read slave1 then slave3 back-to-back -> slave3 stb held off until slave1 ack; then issued, both acked.
// - Access 32'h0F000000 (unmapped) -> err exactly 1 cycle after accept, fault_o pulse, fault_adr_o=32'h0F000000.
// - TIMEOUT=16, slave never acks -> wbm_err_o on cycle 16 after accept, out_cnt=0, next access proceeds.
// - Drop wbm_cyc_i with 2 outstanding; later ack ignored; assert wb_rst_i mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_slave_splitter.sv
// Single-master, multi-slave pipelined Wishbone address splitter.
// Routes each request to the lowest-indexed matching slave, keeps the bus locked
// to one slave while responses are pending, and turns unmapped addresses and
// silent slaves into bus errors with a captured fault address.
module wb_slave_splitter #(
    parameter int unsigned        NS         = 6,
    parameter logic [NS*32-1:0]   SLAVE_ADDR = {NS{32'h0}},
    parameter logic [NS*32-1:0]   SLAVE_MASK = {NS{32'h0}},
    parameter int unsigned        MAX_OUT    = 4,
    parameter int unsigned        TIMEOUT    = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbm_cyc_i,
    input  logic                wbm_stb_i,
    input  logic                wbm_we_i,
    input  logic [31:0]         wbm_adr_i,
    input  logic [31:0]         wbm_dat_i,
    input  logic [3:0]          wbm_sel_i,
    output logic                wbm_ack_o,
    output logic                wbm_err_o,
    output logic                wbm_stall_o,
    output logic [31:0]         wbm_dat_o,
    output logic [NS-1:0]       wbs_cyc_o,
    output logic [NS-1:0]       wbs_stb_o,
    output logic                wbs_we_o,
    output logic [31:0]         wbs_adr_o,
    output logic [31:0]         wbs_dat_o,
    output logic [3:0]          wbs_sel_o,
    input  logic [NS-1:0]       wbs_ack_i,
    input  logic [NS-1:0]       wbs_err_i,
    input  logic [NS-1:0]       wbs_stall_i,
    input  logic [NS*32-1:0]    wbs_dat_i,
    output logic                fault_o,
    output logic [31:0]         fault_adr_o
);

    localparam int unsigned IW    = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned CW    = $clog2(MAX_OUT + 1);
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_MISS_ERR = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   cur;
    logic [CW-1:0]   out_cnt;
    logic [TW-1:0]   timer;
    logic [31:0]     last_adr;

    logic [NS-1:0]   hit;
    logic [IW-1:0]   idx;
    logic            miss;
    logic            is_active;
    logic            is_miss;
    logic            req;
    logic            full;
    logic            timeout_now;
    logic            int_stall;
    logic [IW-1:0]   target;
    logic            tgt_stall;
    logic            slv_stall;
    logic            accept;
    logic            acc_hit;
    logic            acc_miss;
    logic            cur_ack;
    logic            cur_err;
    logic            cur_rsp;
    logic [31:0]     cur_dat;
    logic            run;

    // Address decode: per-slave match and lowest-index priority select
    always_comb begin
        hit = '0;
        idx = '0;
        for (int i = 0; i < int'(NS); i++) begin
            hit[i] = ((wbm_adr_i ^ SLAVE_ADDR[32*i +: 32]) & SLAVE_MASK[32*i +: 32]) == 32'h0;
        end
        for (int i = int'(NS) - 1; i >= 0; i--) begin
            if (hit[i]) idx = IW'(i);
        end
        miss = ~|hit;
    end

    // Select the locked slave's response and the target slave's stall
    always_comb begin
        cur_ack   = 1'b0;
        cur_err   = 1'b0;
        cur_dat   = 32'h0;
        tgt_stall = 1'b0;
        target    = is_active ? cur : idx;
        for (int i = 0; i < int'(NS); i++) begin
            if (cur == IW'(i)) begin
                cur_ack = wbs_ack_i[i];
                cur_err = wbs_err_i[i];
                cur_dat = wbs_dat_i[32*i +: 32];
            end
            if (target == IW'(i)) tgt_stall = wbs_stall_i[i];
        end
    end

    // Handshake qualification: stall sources and request acceptance
    always_comb begin
        run         = ~wb_rst_i;
        is_active   = (state == ST_ACTIVE);
        is_miss     = (state == ST_MISS_ERR);
        req         = wbm_cyc_i & wbm_stb_i;
        full        = (out_cnt == CW'(MAX_OUT));
        timeout_now = TO_EN & is_active & (timer == TO_LAST);
        // A request arriving in the timeout cycle is held off; its slave cyc is being dropped.
        int_stall   = is_miss | full | (is_active & (miss | (idx != cur))) | timeout_now;
        slv_stall   = ~miss & tgt_stall;
        accept      = req & ~int_stall & ~slv_stall;
        acc_hit     = accept & ~miss;
        acc_miss    = accept & miss;
        cur_rsp     = is_active & (cur_ack | cur_err);
    end

    // Master-side response and slave-side request fan-out, all quiet during reset
    always_comb begin
        wbm_ack_o   = run & wbm_cyc_i & is_active & cur_ack;
        wbm_err_o   = run & wbm_cyc_i & ((is_active & cur_err) | is_miss | timeout_now);
        wbm_stall_o = run & req & (int_stall | slv_stall);
        wbm_dat_o   = (run & is_active) ? cur_dat : 32'h0;
        wbs_we_o    = run & wbm_we_i;
        wbs_adr_o   = run ? wbm_adr_i : 32'h0;
        wbs_dat_o   = run ? wbm_dat_i : 32'h0;
        wbs_sel_o   = run ? wbm_sel_i : 4'h0;
        wbs_cyc_o   = '0;
        wbs_stb_o   = '0;
        for (int i = 0; i < int'(NS); i++) begin
            wbs_cyc_o[i] = run & wbm_cyc_i & ~timeout_now &
                           (is_active ? (cur == IW'(i)) : (wbm_stb_i & ~miss & (idx == IW'(i))));
            wbs_stb_o[i] = wbs_cyc_o[i] & wbm_stb_i & ~int_stall;
        end
    end

    // Control FSM: outstanding count, slave lock, timeout timer and fault capture
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            cur         <= '0;
            out_cnt     <= '0;
            timer       <= '0;
            last_adr    <= 32'h0;
            fault_o     <= 1'b0;
            fault_adr_o <= 32'h0;
        end else begin
            fault_o <= 1'b0;
            if (!wbm_cyc_i) begin
                state   <= ST_IDLE;
                out_cnt <= '0;
                timer   <= '0;
            end else if (timeout_now) begin
                state       <= ST_IDLE;
                out_cnt     <= '0;
                timer       <= '0;
                fault_o     <= 1'b1;
                fault_adr_o <= last_adr;
            end else begin
                case (state)
                    ST_IDLE: begin
                        timer <= '0;
                        if (acc_hit) begin
                            state    <= ST_ACTIVE;
                            cur      <= idx;
                            out_cnt  <= CW'(1);
                            last_adr <= wbm_adr_i;
                        end else if (acc_miss) begin
                            // Error is reported in the following cycle, with the fault already latched
                            state       <= ST_MISS_ERR;
                            fault_o     <= 1'b1;
                            fault_adr_o <= wbm_adr_i;
                        end
                    end
                    ST_ACTIVE: begin
                        if (acc_hit) last_adr <= wbm_adr_i;
                        if (acc_hit && !cur_rsp) begin
                            out_cnt <= out_cnt + CW'(1);
                        end else if (!acc_hit && cur_rsp) begin
                            out_cnt <= out_cnt - CW'(1);
                            if (out_cnt == CW'(1)) state <= ST_IDLE;
                        end
                        timer <= (acc_hit || cur_rsp) ? '0 : timer + TW'(1);
                    end
                    ST_MISS_ERR: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_splitter.sv
// Directed bench for wb_slave_splitter: six slaves at 0x0i000000/ffffffc0,
// MAX_OUT=4, TIMEOUT=16. The bench plays both master and slaves.
module tb_wb_slave_splitter;

    logic         clk;
    logic         rst;
    logic         cyc, stb, we;
    logic [31:0]  adr, wdat;
    logic [3:0]   sel;
    logic         wbm_ack_o, wbm_err_o, wbm_stall_o;
    logic [31:0]  wbm_dat_o;
    logic [5:0]   wbs_cyc_o, wbs_stb_o;
    logic         wbs_we_o;
    logic [31:0]  wbs_adr_o, wbs_dat_o;
    logic [3:0]   wbs_sel_o;
    logic [5:0]   s_ack, s_err, s_stall;
    logic [191:0] s_dat;
    logic         fault_o;
    logic [31:0]  fault_adr_o;

    int errors = 0;
    int checks = 0;

    wb_slave_splitter #(
        .NS         (6),
        .SLAVE_ADDR ({32'h05000000, 32'h04000000, 32'h03000000,
                      32'h02000000, 32'h01000000, 32'h00000000}),
        .SLAVE_MASK ({6{32'hffffffc0}}),
        .MAX_OUT    (4),
        .TIMEOUT    (16)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbm_cyc_i   (cyc),
        .wbm_stb_i   (stb),
        .wbm_we_i    (we),
        .wbm_adr_i   (adr),
        .wbm_dat_i   (wdat),
        .wbm_sel_i   (sel),
        .wbm_ack_o   (wbm_ack_o),
        .wbm_err_o   (wbm_err_o),
        .wbm_stall_o (wbm_stall_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_adr_o   (wbs_adr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_ack_i   (s_ack),
        .wbs_err_i   (s_err),
        .wbs_stall_i (s_stall),
        .wbs_dat_i   (s_dat),
        .fault_o     (fault_o),
        .fault_adr_o (fault_adr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h02000004;
        #2;
        checks++; if (wbs_cyc_o !== 6'b0) begin errors++; $display("FAIL rst_cyc: got %b want 000000", wbs_cyc_o); end
        checks++; if (wbm_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", wbm_stall_o); end
        checks++; if (wbs_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr: got %h want 00000000", wbs_adr_o); end
        checks++; if (fault_o !== 1'b0 || fault_adr_o !== 32'h0) begin errors++; $display("FAIL rst_fault: got %b/%h want 0/00000000", fault_o, fault_adr_o); end
        step();
        step();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0;
    endtask

    task automatic test_single_read();
        step();
        cyc = 1'b1; stb = 1'b1; adr = 32'h02000004;
        #1;
        checks++; if (wbs_stb_o !== 6'b000100 || wbm_stall_o !== 1'b0) begin errors++; $display("FAIL rd_issue: stb=%b stall=%b want 000100/0", wbs_stb_o, wbm_stall_o); end
        checks++; if (wbs_adr_o !== 32'h02000004) begin errors++; $display("FAIL rd_adr: got %h want 02000004", wbs_adr_o); end
        step();
        stb = 1'b0;
        #1;
        checks++; if (wbm_ack_o !== 1'b0 || wbs_cyc_o !== 6'b000100 || wbs_stb_o !== 6'b0) begin errors++; $display("FAIL rd_wait: ack=%b cyc=%b stb=%b want 0/000100/000000", wbm_ack_o, wbs_cyc_o, wbs_stb_o); end
        step();
        s_ack = 6'b000100;
        #1;
        checks++; if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hD0000002) begin errors++; $display("FAIL rd_ack: ack=%b dat=%h want 1/d0000002", wbm_ack_o, wbm_dat_o); end
        step();
        s_ack = 6'b0; cyc = 1'b0;
        #1;
        checks++; if (wbm_ack_o !== 1'b0 || wbs_cyc_o !== 6'b0) begin errors++; $display("FAIL rd_end: ack=%b cyc=%b want 0/000000", wbm_ack_o, wbs_cyc_o); end
    endtask

    task automatic test_outstanding();
        for (int k = 0; k < 4; k++) begin
            step();
            cyc = 1'b1; stb = 1'b1; adr = 32'(k * 4);
            #1;
            checks++; if (wbm_stall_o !== 1'b0) begin errors++; $display("FAIL out_req%0d: stall=%b want 0", k, wbm_stall_o); end
        end
        step();
        adr = 32'h00000010;
        #1;
        checks++; if (wbm_stall_o !== 1'b1 || wbs_stb_o !== 6'b0 || wbs_cyc_o !== 6'b000001) begin errors++; $display("FAIL out_full: stall=%b stb=%b cyc=%b want 1/000000/000001", wbm_stall_o, wbs_stb_o, wbs_cyc_o); end
        step();
        s_ack = 6'b000001;
        #1;
        checks++; if (wbm_stall_o !== 1'b1 || wbm_ack_o !== 1'b1) begin errors++; $display("FAIL out_ack1: stall=%b ack=%b want 1/1", wbm_stall_o, wbm_ack_o); end
        step();
        s_ack = 6'b0;
        #1;
        checks++; if (wbm_stall_o !== 1'b0 || wbs_stb_o !== 6'b000001) begin errors++; $display("FAIL out_5th: stall=%b stb=%b want 0/000001", wbm_stall_o, wbs_stb_o); end
        step();
        stb = 1'b0; s_ack = 6'b000001;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            #1;
            checks++; if (wbm_ack_o !== 1'b1) begin errors++; $display("FAIL out_drain%0d: ack=%b want 1", k, wbm_ack_o); end
        end
        step();
        s_ack = 6'b0;
        #1;
        checks++; if (wbs_cyc_o !== 6'b0) begin errors++; $display("FAIL out_idle: cyc=%b want 000000", wbs_cyc_o); end
        cyc = 1'b0;
    endtask

    task automatic test_back_to_back();
        step();
        cyc = 1'b1; stb = 1'b1; adr = 32'h01000000;
        #1;
        checks++; if (wbs_stb_o !== 6'b000010 || wbm_stall_o !== 1'b0) begin errors++; $display("FAIL b2b_s1: stb=%b stall=%b want 000010/0", wbs_stb_o, wbm_stall_o); end
        step();
        adr = 32'h03000000;
        #1;
        checks++; if (wbm_stall_o !== 1'b1 || wbs_stb_o !== 6'b0 || wbs_cyc_o !== 6'b000010) begin errors++; $display("FAIL b2b_hold: stall=%b stb=%b cyc=%b want 1/000000/000010", wbm_stall_o, wbs_stb_o, wbs_cyc_o); end
        step();
        s_ack = 6'b000010;
        #1;
        checks++; if (wbm_ack_o !== 1'b1 || wbm_stall_o !== 1'b1 || wbm_dat_o !== 32'hD0000001) begin errors++; $display("FAIL b2b_ack1: ack=%b stall=%b dat=%h want 1/1/d0000001", wbm_ack_o, wbm_stall_o, wbm_dat_o); end
        step();
        s_ack = 6'b0;
        #1;
        checks++; if (wbm_stall_o !== 1'b0 || wbs_stb_o !== 6'b001000) begin errors++; $display("FAIL b2b_s3: stall=%b stb=%b want 0/001000", wbm_stall_o, wbs_stb_o); end
        step();
        stb = 1'b0; s_ack = 6'b001000;
        #1;
        checks++; if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hD0000003) begin errors++; $display("FAIL b2b_ack3: ack=%b dat=%h want 1/d0000003", wbm_ack_o, wbm_dat_o); end
        step();
        s_ack = 6'b0; cyc = 1'b0;
    endtask

    task automatic test_unmapped();
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0F000000;
        #1;
        checks++; if (wbm_stall_o !== 1'b0 || wbs_cyc_o !== 6'b0 || wbm_err_o !== 1'b0) begin errors++; $display("FAIL miss_acc: stall=%b cyc=%b err=%b want 0/000000/0", wbm_stall_o, wbs_cyc_o, wbm_err_o); end
        step();
        stb = 1'b0; we = 1'b0;
        #1;
        checks++; if (wbm_err_o !== 1'b1 || fault_o !== 1'b1 || fault_adr_o !== 32'h0F000000) begin errors++; $display("FAIL miss_err: err=%b fault=%b adr=%h want 1/1/0f000000", wbm_err_o, fault_o, fault_adr_o); end
        step();
        #1;
        checks++; if (wbm_err_o !== 1'b0 || fault_o !== 1'b0 || fault_adr_o !== 32'h0F000000) begin errors++; $display("FAIL miss_after: err=%b fault=%b adr=%h want 0/0/0f000000", wbm_err_o, fault_o, fault_adr_o); end
        cyc = 1'b0;
    endtask

    task automatic test_timeout();
        step();
        cyc = 1'b1; stb = 1'b1; adr = 32'h04000010;
        #1;
        checks++; if (wbs_stb_o !== 6'b010000) begin errors++; $display("FAIL to_issue: stb=%b want 010000", wbs_stb_o); end
        step();
        stb = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) step();
            #1;
            if (k < 16) begin
                checks++; if (wbm_err_o !== 1'b0) begin errors++; $display("FAIL to_early%0d: err=%b want 0", k, wbm_err_o); end
            end else begin
                checks++; if (wbm_err_o !== 1'b1 || wbs_cyc_o !== 6'b0) begin errors++; $display("FAIL to_fire: err=%b cyc=%b want 1/000000", wbm_err_o, wbs_cyc_o); end
            end
        end
        step();
        stb = 1'b1; adr = 32'h05000000;
        #1;
        checks++; if (wbm_err_o !== 1'b0 || fault_o !== 1'b1 || fault_adr_o !== 32'h04000010) begin errors++; $display("FAIL to_fault: err=%b fault=%b adr=%h want 0/1/04000010", wbm_err_o, fault_o, fault_adr_o); end
        checks++; if (wbm_stall_o !== 1'b0 || wbs_stb_o !== 6'b100000) begin errors++; $display("FAIL to_next: stall=%b stb=%b want 0/100000", wbm_stall_o, wbs_stb_o); end
        step();
        stb = 1'b0; s_ack = 6'b100000;
        #1;
        checks++; if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hD0000005) begin errors++; $display("FAIL to_ack5: ack=%b dat=%h want 1/d0000005", wbm_ack_o, wbm_dat_o); end
        step();
        s_ack = 6'b0; cyc = 1'b0;
    endtask

    task automatic test_slave_err();
        step();
        cyc = 1'b1; stb = 1'b1; adr = 32'h01000020;
        step();
        stb = 1'b0; s_err = 6'b000010;
        #1;
        checks++; if (wbm_err_o !== 1'b1 || wbm_ack_o !== 1'b0) begin errors++; $display("FAIL serr_err: err=%b ack=%b want 1/0", wbm_err_o, wbm_ack_o); end
        step();
        s_err = 6'b0;
        #1;
        checks++; if (wbm_err_o !== 1'b0 || fault_o !== 1'b0 || fault_adr_o !== 32'h04000010) begin errors++; $display("FAIL serr_after: err=%b fault=%b adr=%h want 0/0/04000010", wbm_err_o, fault_o, fault_adr_o); end
        cyc = 1'b0;
    endtask

    task automatic test_cyc_drop_reset();
        step();
        cyc = 1'b1; stb = 1'b1; adr = 32'h02000000;
        step();
        adr = 32'h02000004;
        #1;
        checks++; if (wbm_stall_o !== 1'b0) begin errors++; $display("FAIL drop_req2: stall=%b want 0", wbm_stall_o); end
        step();
        cyc = 1'b0; stb = 1'b0;
        #1;
        checks++; if (wbs_cyc_o !== 6'b0 || wbs_stb_o !== 6'b0) begin errors++; $display("FAIL drop_cyc: cyc=%b stb=%b want 000000/000000", wbs_cyc_o, wbs_stb_o); end
        step();
        s_ack = 6'b000100;
        #1;
        checks++; if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) begin errors++; $display("FAIL drop_late: ack=%b err=%b want 0/0", wbm_ack_o, wbm_err_o); end
        step();
        s_ack = 6'b0; cyc = 1'b1; stb = 1'b1; adr = 32'h03000000;
        #1;
        checks++; if (wbm_stall_o !== 1'b0 || wbs_stb_o !== 6'b001000) begin errors++; $display("FAIL drop_next: stall=%b stb=%b want 0/001000", wbm_stall_o, wbs_stb_o); end
        step();
        rst = 1'b1; adr = 32'h03000004; s_ack = 6'b001000;
        #1;
        checks++; if (wbs_cyc_o !== 6'b0 || wbs_stb_o !== 6'b0 || wbm_stall_o !== 1'b0 || wbm_ack_o !== 1'b0) begin errors++; $display("FAIL mid_rst: cyc=%b stb=%b stall=%b ack=%b want all 0", wbs_cyc_o, wbs_stb_o, wbm_stall_o, wbm_ack_o); end
        checks++; if (wbs_adr_o !== 32'h0 || fault_adr_o !== 32'h0) begin errors++; $display("FAIL mid_rst_adr: adr=%h fault_adr=%h want 0/0", wbs_adr_o, fault_adr_o); end
        step();
        rst = 1'b0; s_ack = 6'b0; cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'h0; wdat = 32'h12345678; sel = 4'hF;
        s_ack = 6'b0; s_err = 6'b0; s_stall = 6'b0;
        for (int i = 0; i < 6; i++) s_dat[32*i +: 32] = 32'hD0000000 | 32'(i);
        test_reset();
        test_single_read();
        test_outstanding();
        test_back_to_back();
        test_unmapped();
        test_timeout();
        test_slave_err();
        test_cyc_drop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
